// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 8:1 cascade mux: steps the select code through
// all channels, samples the mux output after a settle time, and publishes an 8-bit word.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  output logic [2:0] sel,
  input  logic       mux_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHD_W   = DATA_W - 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHD_W-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]   sel_d;
  logic               busy_d;
  logic               done_d;
  logic [DATA_W-1:0]  data_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel      <= sel_d;
      busy     <= busy_d;
      done     <= done_d;
      data     <= data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel;
    busy_d   = busy;
    done_d   = 1'b0;
    data_d   = data;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sel_d   = '0;
          cnt_d   = RELOAD;
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          sel_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (abort) begin
          // abort outranks scan completion: no done, data untouched
          state_d  = IDLE;
          sel_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (sel != LAST_CH) begin
          for (int i = 0; i < int'(SHD_W); i++) begin
            if (sel == SEL_W'(i)) shadow_d[i] = mux_y;
          end
          sel_d   = sel + SEL_W'(1);
          cnt_d   = RELOAD;
          state_d = SETTLE;
        end else begin
          data_d = {mux_y, shadow_q};
          done_d = 1'b1;
          sel_d  = '0;
          if (continuous) begin
            cnt_d   = RELOAD;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8:1 mux feeding mux_y.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, continuous, abort;
  logic [2:0] sel;
  logic       mux_y, busy, done;
  logic [7:0] data;
  logic [7:0] in_vec;

  logic       start3;
  logic [2:0] sel3;
  logic       mux_y3, busy3, done3;
  logic [7:0] data3;
  logic [7:0] in_vec3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_y  = in_vec[sel];
  assign mux_y3 = in_vec3[sel3];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .sel(sel), .mux_y(mux_y), .busy(busy), .done(done), .data(data)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .continuous(1'b0), .abort(1'b0),
    .sel(sel3), .mux_y(mux_y3), .busy(busy3), .done(done3), .data(data3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge right after start was accepted (edge 0).
  task automatic watch_scan(input logic [7:0] exp_data, input logic [7:0] prev_data,
                            input int pulse_k);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sel_k%0d", k), 32'(sel), 32'(k / 2));
      check($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
      check($sformatf("nodone_k%0d", k), 32'(done), 32'd0);
      check($sformatf("data_hold_k%0d", k), 32'(data), 32'(prev_data));
      start = (k == pulse_k);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("data_word", 32'(data), 32'(exp_data));
    check("busy_end", 32'(busy), 32'd0);
    check("sel_wrap", 32'(sel), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_stays_low", 32'(busy), 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    start3 = 1'b0; in_vec = 8'h00; in_vec3 = 8'h01;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan
    in_vec = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_scan(8'hA5, 8'h00, 99);

    // Continuous scan: two words back to back
    in_vec = 8'h3C; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("cont1_busy_k%0d", k), 32'(busy), 32'd1);
      check($sformatf("cont1_nodone_k%0d", k), 32'(done), 32'd0);
      @(negedge clk);
    end
    check("cont_done1", 32'(done), 32'd1);
    check("cont_data1", 32'(data), 32'h3C);
    check("cont_busy_kept", 32'(busy), 32'd1);
    check("cont_sel_wrap", 32'(sel), 32'd0);
    in_vec = 8'hC3; continuous = 1'b0;
    for (int k = 17; k < 32; k++) begin
      @(negedge clk);
      check($sformatf("cont2_busy_k%0d", k), 32'(busy), 32'd1);
      check($sformatf("cont2_nodone_k%0d", k), 32'(done), 32'd0);
      check($sformatf("cont2_data_k%0d", k), 32'(data), 32'h3C);
    end
    @(negedge clk);
    check("cont_done2", 32'(done), 32'd1);
    check("cont_data2", 32'(data), 32'hC3);
    check("cont_busy_end", 32'(busy), 32'd0);
    @(negedge clk);

    // start during a scan is ignored
    in_vec = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_scan(8'h5A, 8'hC3, 6);

    // abort at sel=4
    in_vec = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    check("abort_at_sel4", 32'(sel), 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", 32'(saw_done), 32'd0);
    check("abort_data_kept", 32'(data), 32'h5A);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    @(negedge clk);

    // asynchronous reset mid-cycle at sel=5
    in_vec = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    check("rst_at_sel5", 32'(sel), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_data", 32'(data), 32'd0);
    @(negedge clk);
    check("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_scan(8'h96, 8'h00, 99);

    // SETTLE_CYCLES=3 instance
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("s3_sel_k%0d", k), 32'(sel3), 32'(k / 4));
      check($sformatf("s3_nodone_k%0d", k), 32'(done3), 32'd0);
      @(negedge clk);
    end
    check("s3_done", 32'(done3), 32'd1);
    check("s3_data", 32'(data3), 32'h01);
    check("s3_busy_end", 32'(busy3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles a select value is held before mux output is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one scan of all 8 mux channels.
REQ-005 SHALL have port continuous  input  1  when high at end of scan, restart immediately.
REQ-006 SHALL have port abort  input  1  synchronous cancel of scan in progress.
REQ-007 SHALL have port sel  output  3  select code driven to the downstream 8:1 cascade mux.
REQ-008 SHALL have port mux_y  input  1  output of the 8:1 cascade mux.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a scan word completes.
REQ-011 SHALL have port data  output  8  last completed scan word; bit i = mux_y sampled while sel==i.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE; all outputs registered.
REQ-013 IDLE: start high at an edge -> sel<=0, settle counter<=SETTLE_CYCLES-1, state<=SETTLE, busy<=1.
REQ-014 SETTLE: hold sel; counter decrements each cycle; at counter==0 -> SAMPLE; SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-015 SAMPLE: at the edge ending SAMPLE, shadow[sel]<=mux_y.
REQ-016 SAMPLE with sel<7: sel<=sel+1, counter reload, state<=SETTLE.
REQ-017 SAMPLE with sel==7: data<={mux_y, shadow[6:0]}, done<=1 for exactly one cycle, sel<=0.
REQ-018 End of scan with continuous high: state<=SETTLE, busy stays 1, no idle cycle; continuous low: state<=IDLE, busy<=0.
REQ-019 Each channel SHALL take SETTLE_CYCLES+1 cycles; scan period 8*(SETTLE_CYCLES+1) cycles; start accepted at edge 0 -> done high in cycle after edge 8*(SETTLE_CYCLES+1).
REQ-020 start while busy SHALL be ignored (no restart, no queueing).
REQ-021 abort high in SETTLE or SAMPLE -> state<=IDLE, sel<=0, busy<=0, data unchanged, no done, shadow discarded; abort has priority over scan completion in the same cycle.
REQ-022 abort and start high together in IDLE -> abort wins, stays IDLE.
REQ-023 data SHALL change only on the done edge; stable between scans.
REQ-024 sel SHALL never exceed 7; wrap 7->0 only at scan end.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, sel=0, busy=0, done=0, data=8'h00, shadow=0, counter=0.
REQ-026 rst_n low mid-scan SHALL cancel the scan with no done pulse; operation resumes only on new start after rst_n high.
REQ-027 Release of rst_n SHALL be sampled synchronously; first start accepted on first edge with rst_n high.

Verification
REQ-028 Reset: assert rst_n=0 asynchronously mid-cycle -> sel=0, busy=0, done=0, data=8'h00 immediately.
REQ-029 Single scan, SETTLE_CYCLES=1, bench 8:1 mux model inputs 8'hA5: start pulse -> sel sequence 0,0,1,1,...,7,7; done pulse in cycle after edge 16; data=8'hA5; busy low after.
REQ-030 Continuous, SETTLE_CYCLES=1: inputs 8'h3C then changed to 8'hC3 after first done -> done every 16 cycles, data 8'h3C then 8'hC3, busy never drops.
REQ-031 start pulsed at sel=3 during scan -> ignored, done still at edge 16; then abort at sel=4 on a second scan -> IDLE next cycle, data retains prior value, no done.
REQ-032 SETTLE_CYCLES=3, inputs 8'h01: done in cycle after edge 32, data=8'h01.
REQ-033 rst_n pulsed low at sel=5 -> all outputs reset, no done; new start -> full correct scan.
